muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multiply/divide unit: 2-cycle 32x32 multiply and 32-iteration restoring divide,
// producing HI/LO write data with a single-cycle write-enable pulse.
module muldiv_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mult_en,
    input  logic        div_en,
    input  logic        is_signed,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        md_busy,
    output logic        md_wen,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        signed_q, signed_d;
    logic [63:0] res_q, res_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;

    logic        a_neg, b_neg;
    logic [31:0] b_mag, src1_mag;
    logic [63:0] product;
    logic [32:0] shifted, diff;
    logic        no_borrow;
    logic [31:0] rem_step, quo_step, rem_fix, quo_fix;

    always_comb begin
        a_neg    = signed_q & op_a_q[31];
        b_neg    = signed_q & op_b_q[31];
        b_mag    = b_neg ? (32'd0 - op_b_q) : op_b_q;
        src1_mag = (is_signed & src1[31]) ? (32'd0 - src1) : src1;

        // Sign-extend to 64 bits so the low 64 bits of the product are exact in both modes
        product  = $signed({{32{a_neg}}, op_a_q}) * $signed({{32{b_neg}}, op_b_q});

        // One restoring step; a zero divisor never borrows, giving all-ones quotient
        shifted   = {rem_q, quo_q[31]};
        diff      = shifted - {1'b0, b_mag};
        no_borrow = ~diff[32];
        rem_step  = no_borrow ? diff[31:0] : shifted[31:0];
        quo_step  = {quo_q[30:0], no_borrow};
        quo_fix   = (a_neg ^ b_neg) ? (32'd0 - quo_step) : quo_step;
        rem_fix   = a_neg ? (32'd0 - rem_step) : rem_step;
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        signed_d = signed_q;
        res_d    = res_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle: begin
                if (mult_en || div_en) begin
                    op_a_d   = src1;
                    op_b_d   = src2;
                    signed_d = is_signed;
                    cnt_d    = 6'd0;
                    if (mult_en) begin
                        state_d = StMul;
                    end else begin
                        state_d = StDiv;
                        rem_d   = 32'd0;
                        quo_d   = src1_mag;
                    end
                end
            end
            StMul: begin
                res_d   = product;
                state_d = StDone;
            end
            StDiv: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    res_d   = {rem_fix, quo_fix};
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            signed_q <= 1'b0;
            res_q    <= 64'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            cnt_q    <= 6'd0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            signed_q <= signed_d;
            res_q    <= res_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        md_busy = (state_q == StMul) || (state_q == StDiv);
        md_wen  = (state_q == StDone);
        md_hi   = md_wen ? res_q[63:32] : 32'd0;
        md_lo   = md_wen ? res_q[31:0]  : 32'd0;
    end

endmodule
